// File: rtl/compressor_mc.sv
// compressor_mc: multi-channel dynamic range compressor, one frame of CHANNELS samples per in_valid/in_ready handshake.
// Define COMPRESSOR_MC_LINK_EN for stereo link: one shared gain derived from the loudest channel envelope.
module compressor_mc #(
  parameter int DATA_W        = 16,
  parameter int CHANNELS      = 2,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 thre_para,
  input  logic [1:0]                 ratio_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*CHANNELS-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*CHANNELS-1:0] out_data,
  output logic [16:0]                gain_mon,
  output logic                       over_flag
);
  localparam int EW = DATA_W - 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = DATA_W * CHANNELS;
  localparam int PW = DATA_W + 18;
  localparam logic [16:0]              UNITY  = 17'd32768;
  localparam logic [CW-1:0]            K_LAST = CW'(CHANNELS - 1);
  localparam logic signed [PW-1:0]     Y_MAX  = {{(PW-EW){1'b0}}, {EW{1'b1}}};
  localparam logic signed [PW-1:0]     Y_MIN  = {{(PW-EW){1'b1}}, {EW{1'b0}}};
  localparam logic signed [DATA_W-1:0] X_MIN  = {1'b1, {EW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ENV, S_DIV, S_MUL, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            en_q, en_d;
  logic [EW-1:0]   thr_q, thr_d;
  logic [1:0]      ratio_q, ratio_d;
  logic [EW-1:0]   env_q [CHANNELS];
  logic [EW-1:0]   env_d [CHANNELS];
  logic            over_acc_q, over_acc_d;
  logic [EW-1:0]   rem_q, rem_d, den_q, den_d;
  logic            lsb_q, lsb_d;
  logic [15:0]     quo_q, quo_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            bypass_q, bypass_d;
  logic [16:0]     gain_q, gain_d, gain0_q, gain0_d, gain_mon_q, gain_mon_d;
  logic            out_valid_q, out_valid_d, over_flag_q, over_flag_d;
  logic [FW-1:0]   out_data_q, out_data_d;
`ifdef COMPRESSOR_MC_LINK_EN
  logic [EW-1:0]   env_max_q, env_max_d;
`endif

  logic signed [DATA_W-1:0] x_cur, y;
  logic [EW-1:0]            env_cur, level, env_new, div_env, olev;
  logic                     div_bypass, load_div, rem_ge;
  logic [EW:0]              rem_sh;
  logic [15:0]              quo_next;
  logic [16:0]              gain_fin;
  logic signed [PW-1:0]     prod, prod_sh;

  always_comb begin
    x_cur   = frame_q[k_q*DATA_W +: DATA_W];
    env_cur = env_q[k_q];
    if (x_cur == X_MIN)       level = {EW{1'b1}};
    else if (x_cur[DATA_W-1]) level = EW'(-x_cur);
    else                      level = x_cur[EW-1:0];
    if (level > env_cur) env_new = env_cur + ((level - env_cur) >> ATTACK_SHIFT);
    else                 env_new = env_cur - ((env_cur - level) >> RELEASE_SHIFT);
`ifdef COMPRESSOR_MC_LINK_EN
    div_env  = (env_new > env_max_q) ? env_new : env_max_q;
    load_div = (k_q == K_LAST);
`else
    div_env  = env_new;
    load_div = 1'b1;
`endif
    div_bypass = (div_env <= thr_q) || (ratio_q == 2'd0);
    olev       = thr_q + ((div_env - thr_q) >> ratio_q);
    // Dividend is olev<<15: olev>>1 seeds the remainder and olev[0] enters on the first step.
    rem_sh   = {rem_q, (cnt_q == 4'd0) ? lsb_q : 1'b0};
    rem_ge   = (rem_sh >= {1'b0, den_q});
    quo_next = quo_q;
    quo_next[4'd15 - cnt_q] = rem_ge;
    if (bypass_q || ({1'b0, quo_next} > UNITY)) gain_fin = UNITY;
    else                                         gain_fin = {1'b0, quo_next};
    prod    = PW'(x_cur) * $signed({{(PW-17){1'b0}}, gain_q});
    prod_sh = prod >>> 15;
    if (!en_q)                y = x_cur;
    else if (prod_sh > Y_MAX) y = ~X_MIN;
    else if (prod_sh < Y_MIN) y = X_MIN;
    else                      y = prod_sh[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    frame_d     = frame_q;
    en_d        = en_q;
    thr_d       = thr_q;
    ratio_d     = ratio_q;
    env_d       = env_q;
    over_acc_d  = over_acc_q;
    rem_d       = rem_q;
    den_d       = den_q;
    lsb_d       = lsb_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    bypass_d    = bypass_q;
    gain_d      = gain_q;
    gain0_d     = gain0_q;
    gain_mon_d  = gain_mon_q;
    out_valid_d = out_valid_q;
    over_flag_d = over_flag_q;
    out_data_d  = out_data_q;
`ifdef COMPRESSOR_MC_LINK_EN
    env_max_d   = env_max_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        frame_d    = in_data;
        en_d       = en;
        thr_d      = EW'((32'd5000 + 32'd1000 * 32'(thre_para)) << (DATA_W - 16));
        ratio_d    = ratio_sel;
        k_d        = '0;
        over_acc_d = 1'b0;
`ifdef COMPRESSOR_MC_LINK_EN
        env_max_d  = '0;
`endif
        state_d    = S_ENV;
      end
      S_ENV: begin
        env_d[k_q] = env_new;
        if (env_new > thr_q) over_acc_d = 1'b1;
`ifdef COMPRESSOR_MC_LINK_EN
        env_max_d = div_env;
        if (!load_div) k_d = k_q + 1'b1;
        else           k_d = '0;
`endif
        if (load_div) begin
          rem_d    = div_bypass ? '0 : (olev >> 1);
          lsb_d    = div_bypass ? 1'b0 : olev[0];
          den_d    = div_env;
          bypass_d = div_bypass;
          quo_d    = '0;
          cnt_d    = '0;
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? EW'(rem_sh - {1'b0, den_q}) : rem_sh[EW-1:0];
        quo_d = quo_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          gain_d = gain_fin;
          if (k_q == '0) gain0_d = gain_fin;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        out_data_d[k_q*DATA_W +: DATA_W] = y;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
`ifdef COMPRESSOR_MC_LINK_EN
          state_d = S_MUL;
`else
          state_d = S_ENV;
`endif
        end
      end
      S_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          gain_mon_d  = gain0_q;
          over_flag_d = over_acc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      frame_q     <= '0;
      en_q        <= 1'b0;
      thr_q       <= '0;
      ratio_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) env_q[c] <= '0;
      over_acc_q  <= 1'b0;
      rem_q       <= '0;
      den_q       <= '0;
      lsb_q       <= 1'b0;
      quo_q       <= '0;
      cnt_q       <= '0;
      bypass_q    <= 1'b1;
      gain_q      <= UNITY;
      gain0_q     <= UNITY;
      gain_mon_q  <= UNITY;
      out_valid_q <= 1'b0;
      over_flag_q <= 1'b0;
      out_data_q  <= '0;
`ifdef COMPRESSOR_MC_LINK_EN
      env_max_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      frame_q     <= frame_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      ratio_q     <= ratio_d;
      env_q       <= env_d;
      over_acc_q  <= over_acc_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      lsb_q       <= lsb_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      bypass_q    <= bypass_d;
      gain_q      <= gain_d;
      gain0_q     <= gain0_d;
      gain_mon_q  <= gain_mon_d;
      out_valid_q <= out_valid_d;
      over_flag_q <= over_flag_d;
      out_data_q  <= out_data_d;
`ifdef COMPRESSOR_MC_LINK_EN
      env_max_q   <= env_max_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign gain_mon  = gain_mon_q;
  assign over_flag = over_flag_q;
endmodule

// File: tb/tb_compressor_mc.sv
// Randomized bench for compressor_mc against a frame-level arithmetic reference model.
module tb_compressor_mc;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int AS = 0;
  localparam int RS = 8;
  localparam int FW = DW * CH;
`ifdef COMPRESSOR_MC_LINK_EN
  localparam int EXP_LAT = 2 * CH + 17;
`else
  localparam int EXP_LAT = CH * 18 + 1;
`endif

  logic          clk = 1'b0;
  logic          reset, en, in_valid, in_ready, out_valid, out_ready, over_flag;
  logic [2:0]    thre_para;
  logic [1:0]    ratio_sel;
  logic [FW-1:0] in_data, out_data;
  logic [16:0]   gain_mon;

  compressor_mc #(.DATA_W(DW), .CHANNELS(CH), .ATTACK_SHIFT(AS), .RELEASE_SHIFT(RS)) dut (
    .clk(clk), .reset(reset), .en(en), .thre_para(thre_para), .ratio_sel(ratio_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .gain_mon(gain_mon), .over_flag(over_flag)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  longint        xin [CH];
  longint        env_m [CH];
  longint        exp_y [CH];
  longint        exp_gain0;
  longint        exp_over;
  logic [FW-1:0] exp_pk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint gain_of(input longint env, input longint t, input int r);
    longint olev, g;
    if (env <= t || r == 0) return 32768;
    olev = t + ((env - t) >> r);
    g = (olev * 32768) / env;
    return (g > 32768) ? 32768 : g;
  endfunction

  task automatic model_frame(input bit e, input int th, input int r);
    longint t, lvl, mx, g, y;
    longint gains [CH];
    t  = longint'(5000 + 1000 * th) << (DW - 16);
    mx = 0;
    exp_over = 0;
    for (int c = 0; c < CH; c++) begin
      lvl = (xin[c] < 0) ? -xin[c] : xin[c];
      if (lvl > 32767) lvl = 32767;
      if (lvl > env_m[c]) env_m[c] = env_m[c] + ((lvl - env_m[c]) >> AS);
      else                env_m[c] = env_m[c] - ((env_m[c] - lvl) >> RS);
      if (env_m[c] > t) exp_over = 1;
      if (env_m[c] > mx) mx = env_m[c];
    end
    for (int c = 0; c < CH; c++) begin
`ifdef COMPRESSOR_MC_LINK_EN
      gains[c] = gain_of(mx, t, r);
`else
      gains[c] = gain_of(env_m[c], t, r);
`endif
      if (!e) y = xin[c];
      else begin
        y = (xin[c] * gains[c]) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
      end
      exp_y[c] = y;
      exp_pk[c*DW +: DW] = y[DW-1:0];
    end
    exp_gain0 = gains[0];
  endtask

  function automatic longint out_ch(input int c);
    logic signed [DW-1:0] s;
    s = out_data[c*DW +: DW];
    return longint'(s);
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  task automatic send_frame(input bit e, input int th, input int r);
    for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = xin[c][DW-1:0];
    en = e; thre_para = 3'(th); ratio_sel = 2'(r); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    en = 1'($urandom); thre_para = 3'($urandom); ratio_sel = 2'($urandom);
    in_data = {CH{16'($urandom)}};
  endtask

  task automatic run_frame(input bit e, input int th, input int r, input int hold);
    int lat = 0;
    wait_ready();
    if (!in_ready) begin
      check_val("ready_timeout", 0, 1);
      return;
    end
    send_frame(e, th, r);
    model_frame(e, th, r);
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, EXP_LAT);
    if (!out_valid) return;
    for (int c = 0; c < CH; c++) check_val($sformatf("out_ch%0d", c), out_ch(c), exp_y[c]);
    check_val("gain_mon", gain_mon, exp_gain0);
    check_val("over_flag", over_flag, exp_over);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("stall_valid", out_valid, 1);
      check_val("stall_data", (out_data == exp_pk) ? 1 : 0, 1);
      check_val("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("ready_after_hs", in_ready, 1);
    check_val("valid_after_hs", out_valid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_data"}, out_data, 0);
    check_val({tag, "_gain_mon"}, gain_mon, 32768);
    check_val({tag, "_over_flag"}, over_flag, 0);
  endtask

  function automatic longint rand_sample();
    logic signed [DW-1:0] s;
    case ($urandom_range(0, 3))
      0: s = 16'($urandom);
      1: s = 16'($urandom_range(0, 4000)) - 16'sd2000;
      2: s = 16'h8000;
      default: s = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(15000, 32767))
                                                : -16'($urandom_range(15000, 32767));
    endcase
    return longint'(s);
  endfunction

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b1; en = 1'b1; thre_para = '0; ratio_sel = 2'd1;
    out_ready = 1'b0; in_data = {16'd1234, 16'd30000};
    for (int c = 0; c < CH; c++) env_m[c] = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_state("reset");
    end
    reset = 1'b0; in_valid = 1'b0;
    check_val("ready_after_reset", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_val("no_accept_in_reset", seen, 0);

    for (int f = 0; f < 10; f++) begin
      xin[0] = 4000; xin[1] = 4000;
      run_frame(1'b1, 0, 1, 0);
    end

    xin[0] = 13000; xin[1] = -13000;
    run_frame(1'b1, 0, 1, 0);
    check_val("k13_gain", gain_mon, 22685);
    check_val("k13_ch0", out_ch(0), 8999);
    check_val("k13_ch1", out_ch(1), -9000);
    check_val("k13_over", over_flag, 1);

    xin[0] = 1000; xin[1] = 1000;
    run_frame(1'b1, 0, 1, 0);
    check_val("rel_gain", gain_mon, 22707);
    check_val("rel_ch0", out_ch(0), 692);
    check_val("rel_ch1", out_ch(1), 692);

    xin[0] = -20000; xin[1] = -20000;
    run_frame(1'b0, 0, 1, 0);
    check_val("bypass_ch0", out_ch(0), -20000);
    check_val("bypass_over", over_flag, 1);

    xin[0] = rand_sample(); xin[1] = rand_sample();
    run_frame(1'b1, 2, 2, 50);

    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < CH; c++) xin[c] = rand_sample();
      run_frame(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    wait_ready();
    xin[0] = 30000; xin[1] = -25000;
    send_frame(1'b1, 0, 3);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid_div");
    reset = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < CH; c++) env_m[c] = 0;
    check_val("mid_div_ready_after", in_ready, 1);
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < CH; c++) xin[c] = rand_sample();
      run_frame(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
